// File: rtl/boot_loader_pkg.sv
// Shared state encoding and stream header layout for the program loader.
package boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_BASE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_LOAD  = 3'd2,
    ST_START = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } boot_state_e;

  // Header word positions in the host stream, ahead of the image payload.
  localparam int unsigned HDR_BASE_IDX  = 0;
  localparam int unsigned HDR_COUNT_IDX = 1;
  localparam int unsigned HDR_WORDS     = 2;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned WORD_SHIFT = 2;

endpackage

// File: rtl/boot_write_buffer.sv
// One-entry valid/ready slice holding a pending memory write until accepted.
module boot_write_buffer #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                load_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   data_i,
  input  logic                ready_i,
  output logic                valid_o,
  output logic [DATA_W/8-1:0] byte_en_o,
  output logic [ADDR_W-1:0]   addr_o,
  output logic [DATA_W-1:0]   data_o
);

  logic                valid_q, valid_d;
  logic [DATA_W/8-1:0] byte_en_q, byte_en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;

  // A load in the same cycle as acceptance refills the slot, keeping it full.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      addr_d  = addr_i;
      data_d  = data_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
    byte_en_d = valid_d ? '1 : '0;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q   <= 1'b0;
      byte_en_q <= '0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      valid_q   <= valid_d;
      byte_en_q <= byte_en_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

  assign valid_o   = valid_q;
  assign byte_en_o = byte_en_q;
  assign addr_o    = addr_q;
  assign data_o    = data_q;

endmodule

// File: rtl/boot_loader.sv
// Streams a base/count/payload image into BRAM while holding the core, then
// releases it with a one-cycle start pulse at the image base.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned ADDRESS_BITS     = 32,
  parameter int unsigned MEM_ADDRESS_BITS = 10
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic                    rearm,
  output logic                    mem_write,
  input  logic                    mem_ready,
  output logic [DATA_WIDTH/8-1:0] mem_byte_en,
  output logic [ADDRESS_BITS-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]   mem_data,
  output logic                    core_hold,
  output logic                    start,
  output logic [ADDRESS_BITS-1:0] program_address,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  localparam int unsigned REM_W = MEM_ADDRESS_BITS + 1;
  localparam int unsigned CHK_W =
    ((DATA_WIDTH > ADDRESS_BITS) ? DATA_WIDTH : ADDRESS_BITS) + 1;
  localparam logic [CHK_W-1:0] MEM_WORDS = CHK_W'(1) << MEM_ADDRESS_BITS;

  boot_state_e             state_q, state_d;
  logic [ADDRESS_BITS-1:0] base_q, base_d;
  logic [ADDRESS_BITS-1:0] addr_q, addr_d;
  logic [ADDRESS_BITS-1:0] prog_q, prog_d;
  logic [REM_W-1:0]        rem_q, rem_d;
  logic                    start_q, start_d;
  logic                    hold_q, hold_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;

  logic             xfer;
  logic             buf_free;
  logic             load_xfer;
  logic             too_big;
  logic [CHK_W-1:0] count_ext;
  logic [CHK_W-1:0] base_words;

  assign xfer      = s_valid && s_ready;
  assign buf_free  = !mem_write || mem_ready;
  assign load_xfer = (state_q == ST_LOAD) && xfer;

  // Image bounds are checked one bit wider than the operands so base+count cannot wrap.
  assign count_ext  = CHK_W'(s_data);
  assign base_words = CHK_W'(base_q >> WORD_SHIFT);
  assign too_big    = (count_ext > MEM_WORDS) || ((base_words + count_ext) > MEM_WORDS);

  // Ready must follow mem_ready within the cycle to sustain one word per cycle.
  always_comb begin
    s_ready = 1'b0;
    unique case (state_q)
      ST_BASE, ST_COUNT: s_ready = 1'b1;
      ST_LOAD:           s_ready = (rem_q != '0) && buf_free;
      default:           s_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    unique case (state_q)
      ST_BASE: begin
        if (xfer) begin
          base_d  = ADDRESS_BITS'(s_data);
          state_d = (s_data[1:0] != 2'b00) ? ST_ERROR : ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (xfer) begin
          if (s_data == '0) begin
            state_d = ST_START;
          end else if (too_big) begin
            state_d = ST_ERROR;
          end else begin
            addr_d  = base_q;
            rem_d   = REM_W'(s_data);
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (xfer) begin
          addr_d = addr_q + ADDRESS_BITS'(WORD_BYTES);
          rem_d  = rem_q - REM_W'(1);
        end
        if ((rem_q == '0) && buf_free) begin
          state_d = ST_START;
        end
      end
      ST_START: state_d = ST_DONE;
      ST_DONE:  if (rearm) state_d = ST_BASE;
      ST_ERROR: if (rearm) state_d = ST_BASE;
      default:  state_d = ST_BASE;
    endcase
  end

  // Status outputs are registered copies of the decoded next state.
  always_comb begin
    start_d = (state_d == ST_START);
    busy_d  = (state_d == ST_COUNT) || (state_d == ST_LOAD) || (state_d == ST_START);
    done_d  = (state_d == ST_DONE);
    error_d = (state_d == ST_ERROR);
    hold_d  = !((state_d == ST_START) || (state_d == ST_DONE));
    prog_d  = start_d ? base_q : prog_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_BASE;
      base_q  <= '0;
      addr_q  <= '0;
      rem_q   <= '0;
      prog_q  <= '0;
      start_q <= 1'b0;
      hold_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      prog_q  <= prog_d;
      start_q <= start_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  boot_write_buffer #(
    .ADDR_W (ADDRESS_BITS),
    .DATA_W (DATA_WIDTH)
  ) u_wbuf (
    .clock_i   (clock),
    .reset_i   (reset),
    .load_i    (load_xfer),
    .addr_i    (addr_q),
    .data_i    (s_data),
    .ready_i   (mem_ready),
    .valid_o   (mem_write),
    .byte_en_o (mem_byte_en),
    .addr_o    (mem_address),
    .data_o    (mem_data)
  );

  assign core_hold       = hold_q;
  assign start           = start_q;
  assign program_address = prog_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign error           = error_q;

endmodule

// File: tb/tb_boot_loader.sv
// Randomized image loads checked against a queue-based model of the expected
// header decode, memory writes and start behaviour.
module tb_boot_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        rearm;
  logic        mem_write;
  logic        mem_ready;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_address;
  logic [31:0] mem_data;
  logic        core_hold;
  logic        start;
  logic [31:0] program_address;
  logic        busy;
  logic        done;
  logic        error;

  boot_loader #(
    .DATA_WIDTH       (32),
    .ADDRESS_BITS     (32),
    .MEM_ADDRESS_BITS (10)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .s_data          (s_data),
    .rearm           (rearm),
    .mem_write       (mem_write),
    .mem_ready       (mem_ready),
    .mem_byte_en     (mem_byte_en),
    .mem_address     (mem_address),
    .mem_data        (mem_data),
    .core_hold       (core_hold),
    .start           (start),
    .program_address (program_address),
    .busy            (busy),
    .done            (done),
    .error           (error)
  );

  always #5 clock = ~clock;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  logic [31:0] tx_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] exp_prog;
  logic [31:0] last_prog = 32'h0;
  int          cyc = 0;
  int          n_starts, n_writes, xfer_idx;
  int          last_write_cyc, last_xfer_cyc, first_data_cyc;
  bit          full_rate;
  int          ready_mode;
  bit          prev_pend = 1'b0;
  logic [31:0] prev_addr, prev_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Observes the handshakes that will complete at the coming clock edge.
  task automatic monitor();
    cyc++;
    check("byte_en", 64'(mem_byte_en), mem_write ? 64'hF : 64'h0);
    if (prev_pend) begin
      check("hold_valid", 64'(mem_write), 64'd1);
      check("hold_addr", 64'(mem_address), 64'(prev_addr));
      check("hold_data", 64'(mem_data), 64'(prev_data));
    end
    if (mem_write && !mem_ready) check("sready_full", 64'(s_ready), 64'd0);
    if (s_valid && s_ready) begin
      if (xfer_idx == 2) first_data_cyc = cyc;
      xfer_idx++;
      last_xfer_cyc = cyc;
      if (tx_q.size() != 0) void'(tx_q.pop_front());
    end
    if (mem_write && mem_ready) begin
      check("wr_core_hold", 64'(core_hold), 64'd1);
      if (exp_addr_q.size() == 0) begin
        check("extra_write", 64'd1, 64'd0);
      end else begin
        check("wr_addr", 64'(mem_address), 64'(exp_addr_q.pop_front()));
        check("wr_data", 64'(mem_data), 64'(exp_data_q.pop_front()));
      end
      if (full_rate) begin
        if (n_writes == 0) check("first_wr_lat", 64'(cyc - first_data_cyc), 64'd1);
        else               check("b2b_wr", 64'(cyc - last_write_cyc), 64'd1);
      end
      n_writes++;
      last_write_cyc = cyc;
    end
    if (start) begin
      n_starts++;
      check("start_pc", 64'(program_address), 64'(exp_prog));
      check("start_core_hold", 64'(core_hold), 64'd0);
      check("start_lat", 64'(cyc - ((n_writes != 0) ? last_write_cyc : last_xfer_cyc)), 64'd1);
    end
    prev_pend = mem_write && !mem_ready;
    prev_addr = mem_address;
    prev_data = mem_data;
  endtask

  task automatic cycle();
    #1;
    monitor();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drive();
    s_valid = (tx_q.size() != 0) && (full_rate || ($urandom_range(3) != 0));
    s_data  = (tx_q.size() != 0) ? tx_q[0] : $urandom;
    case (ready_mode)
      0:       mem_ready = 1'b1;
      1:       mem_ready = (cyc % 3 == 0);
      default: mem_ready = 1'($urandom_range(1));
    endcase
    rearm = !done && !error && ($urandom_range(7) == 0);
  endtask

  // Builds the stream and the expected write list from the header rules.
  task automatic setup_image(input logic [31:0] base, input logic [31:0] n, output bit ok);
    logic [63:0] words_end;
    logic [31:0] w;
    words_end = 64'(base >> 2) + 64'(n);
    ok = (base[1:0] == 2'b00) && ((n == 0) || ((n <= 1024) && (words_end <= 64'd1024)));
    tx_q.delete();
    exp_addr_q.delete();
    exp_data_q.delete();
    tx_q.push_back(base);
    if (base[1:0] == 2'b00) tx_q.push_back(n);
    if (ok) begin
      for (int i = 0; i < int'(n); i++) begin
        w = $urandom;
        tx_q.push_back(w);
        exp_addr_q.push_back(base + 32'(4 * i));
        exp_data_q.push_back(w);
      end
    end
    tx_q.push_back($urandom);
    exp_prog = base;
    n_starts = 0;
    n_writes = 0;
    xfer_idx = 0;
  endtask

  task automatic run_image(input logic [31:0] base, input logic [31:0] n,
                           input int rmode, input bit fr);
    bit ok;
    int budget;
    setup_image(base, n, ok);
    ready_mode = rmode;
    full_rate  = fr;
    budget     = 8 * int'(n[15:0]) + 100;
    while (!(done || error) && budget > 0) begin
      drive();
      cycle();
      budget--;
    end
    if (budget == 0) check("timeout", 64'd0, 64'd1);
    rearm = 1'b0;
    repeat (3) begin
      drive();
      cycle();
    end
    check("end_done", 64'(done), 64'(ok));
    check("end_error", 64'(error), 64'(!ok));
    check("end_core_hold", 64'(core_hold), 64'(!ok));
    check("end_busy", 64'(busy), 64'd0);
    check("end_starts", 64'(n_starts), 64'(ok));
    check("end_writes_left", 64'(exp_addr_q.size()), 64'd0);
    check("end_unconsumed", 64'(tx_q.size()), 64'd1);
    if (ok) last_prog = base;
    check("end_pc", 64'(program_address), 64'(last_prog));
    tx_q.delete();
    s_valid = 1'b0;
    rearm   = 1'b1;
    cycle();
    rearm   = 1'b0;
    check("rearm_sready", 64'(s_ready), 64'd1);
    check("rearm_core_hold", 64'(core_hold), 64'd1);
    check("rearm_flags", 64'({done, error, busy}), 64'd0);
    check("rearm_pc_kept", 64'(program_address), 64'(last_prog));
  endtask

  task automatic run_abort();
    bit ok;
    int budget;
    setup_image(32'h0000_0040, 32'd4, ok);
    ready_mode = 2;
    full_rate  = 1'b0;
    budget     = 200;
    while (n_writes < 2 && budget > 0) begin
      drive();
      cycle();
      budget--;
    end
    if (budget == 0) check("abort_timeout", 64'd0, 64'd1);
    #2 reset = 1'b1;
    #1;
    check("abort_sready", 64'(s_ready), 64'd1);
    check("abort_mem", 64'({mem_write, mem_byte_en}), 64'd0);
    check("abort_addr", 64'(mem_address), 64'd0);
    check("abort_data", 64'(mem_data), 64'd0);
    check("abort_core_hold", 64'(core_hold), 64'd1);
    check("abort_pc", 64'(program_address), 64'd0);
    check("abort_flags", 64'({start, busy, done, error}), 64'd0);
    @(negedge clock);
    prev_pend = 1'b0;
    s_valid   = 1'b0;
    rearm     = 1'b0;
    exp_addr_q.delete();
    exp_data_q.delete();
    repeat (2) cycle();
    reset     = 1'b0;
    last_prog = 32'h0;
    check("abort_no_start", 64'(n_starts), 64'd0);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    s_valid   = 1'b0;
    s_data    = 32'h0;
    rearm     = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_sready", 64'(s_ready), 64'd1);
    check("rst_mem", 64'({mem_write, mem_byte_en}), 64'd0);
    check("rst_addr", 64'(mem_address), 64'd0);
    check("rst_data", 64'(mem_data), 64'd0);
    check("rst_core_hold", 64'(core_hold), 64'd1);
    check("rst_pc", 64'(program_address), 64'd0);
    check("rst_flags", 64'({start, busy, done, error}), 64'd0);
    reset = 1'b0;
    @(negedge clock);

    run_image(32'h0000_0100, 32'd3, 0, 1'b1);
    run_image(32'h0000_0100, 32'd3, 1, 1'b0);
    run_image(32'h0000_0102, 32'd3, 0, 1'b0);
    run_image(32'h0000_0FF0, 32'd5, 2, 1'b0);
    run_image(32'h0000_0FF0, 32'd4, 2, 1'b0);
    run_image(32'h0000_0000, 32'd0, 0, 1'b0);
    run_image(32'h0000_1000, 32'd0, 2, 1'b0);
    run_image(32'h0000_1000, 32'd1, 2, 1'b0);
    run_image(32'h0000_0000, 32'd1025, 0, 1'b0);
    run_image(32'h0000_0000, 32'd1024, 0, 1'b1);

    run_abort();
    run_image(32'h0000_0040, 32'd4, 2, 1'b0);
    run_image(32'h0000_0200, 32'd5, 1, 1'b0);

    for (int k = 0; k < 24; k++) begin
      logic [31:0] b;
      logic [31:0] n;
      int          m;
      b = 32'($urandom_range(1030)) << 2;
      n = 32'($urandom_range(12));
      if ($urandom_range(4) == 0) begin
        b = 32'(1000 + $urandom_range(24)) << 2;
        n = 32'(1024 - (b >> 2)) + 32'($urandom_range(1));
      end
      if ($urandom_range(7) == 0) b = b | 32'd2;
      m = int'($urandom_range(2));
      run_image(b, n, m, (m == 0) && ($urandom_range(1) == 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
